pwm_frequency_div: RTL and testbench

Sample-rate decimator for the 16-bit audio path: accumulates 2^RATIO_LOG2 consecutive input samples and emits one rounded boxcar average per block. It is the inverse of the playback-side 8x sample repeater and sits on the capture side, between the high-rate sample source and the low-rate speech-processing chain. Input and output are registered, and valid is signalled by a one-cycle ready pulse.

---
 rtl/pwm_frequency_div.sv | 91 +++++++++
 tb/tb_pwm_frequency_div.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_frequency_div.sv
// Capture-side decimator: averages each block of 2^RATIO_LOG2 unsigned 16-bit
// samples into one round-half-up boxcar mean, with registered input and output.
module pwm_frequency_div #(
    parameter int unsigned RATIO_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    input  logic [15:0] sound,
    input  logic        sound_rdy,
    output logic [15:0] sound_out,
    output logic        sound_out_rdy
);

    localparam int unsigned N  = 1 << RATIO_LOG2;
    localparam int unsigned AW = 16 + RATIO_LOG2;
    localparam int unsigned CW = RATIO_LOG2 + 1;
    localparam logic [AW:0] HALF = (AW + 1)'(N / 2);

    typedef enum logic {ACC, EMIT} state_t;

    state_t          state;
    logic [15:0]     b_sound;
    logic            b_sound_rdy;
    logic            b_sync;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [15:0]     b_sound_out;
    logic            b_sound_out_rdy;

    logic [AW:0]     rounded;
    logic [15:0]     avg;
    logic [AW-1:0]   first_acc;
    logic [CW-1:0]   first_cnt;

    always_comb begin
        rounded   = {1'b0, acc} + HALF;
        avg       = 16'(rounded >> RATIO_LOG2);
        first_acc = b_sound_rdy ? AW'(b_sound) : '0;
        first_cnt = CW'(b_sound_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_sound         <= '0;
            b_sound_rdy     <= 1'b0;
            b_sync          <= 1'b0;
            acc             <= '0;
            cnt             <= '0;
            state           <= ACC;
            b_sound_out     <= '0;
            b_sound_out_rdy <= 1'b0;
            sound_out       <= '0;
            sound_out_rdy   <= 1'b0;
        end else begin
            b_sound       <= sound;
            b_sound_rdy   <= sound_rdy;
            b_sync        <= sync;
            sound_out     <= b_sound_out;
            sound_out_rdy <= b_sound_out_rdy;

            b_sound_out     <= '0;
            b_sound_out_rdy <= 1'b0;

            case (state)
                ACC: begin
                    if (b_sync) begin
                        acc <= first_acc;
                        cnt <= first_cnt;
                    end else if (b_sound_rdy) begin
                        acc <= acc + AW'(b_sound);
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N - 1))
                            state <= EMIT;
                    end
                end
                EMIT: begin
                    // A sample landing in the emit cycle seeds the next block,
                    // so sync here needs no special handling.
                    b_sound_out     <= avg;
                    b_sound_out_rdy <= 1'b1;
                    acc             <= first_acc;
                    cnt             <= first_cnt;
                    state           <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_frequency_div.sv
// Bench for pwm_frequency_div: block-average reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pwm_frequency_div;

    localparam int L = 3;
    localparam int N = 1 << L;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic        sound_rdy = 1'b0;
    logic [15:0] sound = '0;
    logic [15:0] sound_out;
    logic        sound_out_rdy;

    pwm_frequency_div #(.RATIO_LOG2(L)) dut (
        .clk(clk), .rst(rst), .sync(sync), .sound(sound), .sound_rdy(sound_rdy),
        .sound_out(sound_out), .sound_out_rdy(sound_out_rdy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int last_in_edge = 0;

    typedef struct { int due; logic [15:0] val; } pend_t;
    pend_t pend[$];

    int              m_cnt = 0;
    longint unsigned m_sum = 0;
    logic            p_rdy = 1'b0, p_sync = 1'b0;
    logic [15:0]     p_snd = '0;

    logic [15:0] log_val[$];
    int          log_edge[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: a sample seen at edge e joins its block at e+1 (input register);
    // a completed block appears on the outputs two edges after that.
    always @(posedge clk) begin
        logic        exp_rdy;
        logic [15:0] exp_val;
        pend_t       p;
        edge_n++;
        if (rst) begin
            m_cnt = 0; m_sum = 0; pend.delete();
            p_rdy = 1'b0; p_sync = 1'b0; p_snd = '0;
        end else begin
            if (sound_rdy) last_in_edge = edge_n;
            if (p_sync) begin
                m_sum = p_rdy ? longint'(p_snd) : 0;
                m_cnt = p_rdy ? 1 : 0;
            end else if (p_rdy) begin
                m_sum += longint'(p_snd);
                m_cnt++;
            end
            if (m_cnt == N) begin
                p.due = edge_n + 2;
                p.val = 16'((m_sum + N / 2) / N);
                pend.push_back(p);
                m_cnt = 0; m_sum = 0;
            end
            p_rdy = sound_rdy; p_sync = sync; p_snd = sound;
        end
        #1;
        exp_rdy = 1'b0; exp_val = '0;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            exp_rdy = 1'b1; exp_val = pend[0].val;
            void'(pend.pop_front());
        end
        chk("sound_out_rdy", 32'(sound_out_rdy), 32'(exp_rdy));
        chk("sound_out", 32'(sound_out), 32'(exp_val));
        if (sound_out_rdy === 1'b1) begin
            log_val.push_back(sound_out);
            log_edge.push_back(edge_n);
        end
    end

    task automatic step(input logic r, input logic s_rdy, input logic [15:0] s, input logic sy);
        @(negedge clk);
        rst = r; sound_rdy = s_rdy; sound = s; sync = sy;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic clear_log();
        log_val.delete();
        log_edge.delete();
    endtask

    initial begin
        // Reset held three cycles with sound_rdy toggling
        for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 16'hABCD, 1'b0);
        clear_log();
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 16'h0100, 1'b0);
        idle(6);
        chk("reset_count", 32'(log_val.size()), 32'd1);
        chk("reset_val", 32'(log_val[0]), 32'h0100);

        // Constant block, one strobe every 4 cycles
        clear_log();
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, 16'h1234, 1'b0);
            idle(3);
        end
        idle(6);
        chk("const_count", 32'(log_val.size()), 32'd1);
        chk("const_val", 32'(log_val[0]), 32'h1234);
        chk("const_latency", 32'(log_edge[0] - last_in_edge), 32'd3);

        // Rounding boundary: sum 4 rounds up, sum 3 rounds down
        clear_log();
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, (i == N - 1) ? 16'd4 : 16'd0, 1'b0);
        idle(4);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, (i == N - 1) ? 16'd3 : 16'd0, 1'b0);
        idle(6);
        chk("round_count", 32'(log_val.size()), 32'd2);
        chk("round_up", 32'(log_val[0]), 32'h0001);
        chk("round_down", 32'(log_val[1]), 32'h0000);

        // Full scale, back-to-back
        clear_log();
        for (int i = 0; i < 2 * N; i++) step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        idle(6);
        chk("full_count", 32'(log_val.size()), 32'd2);
        chk("full_val0", 32'(log_val[0]), 32'hFFFF);
        chk("full_val1", 32'(log_val[1]), 32'hFFFF);
        chk("full_spacing", 32'(log_edge[1] - log_edge[0]), 32'd8);

        // Ramp with sync landing on sample 100
        clear_log();
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
        step(1'b0, 1'b1, 16'd100, 1'b1);
        for (int i = 101; i <= 107; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
        idle(6);
        chk("sync_count", 32'(log_val.size()), 32'd1);
        chk("sync_val", 32'(log_val[0]), 32'h0068);

        // Reset in the middle of a block
        clear_log();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h8000, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 16'h0010, 1'b0);
        idle(6);
        chk("rstmid_count", 32'(log_val.size()), 32'd1);
        chk("rstmid_val", 32'(log_val[0]), 32'h0010);

        // Random traffic, including sync during emit and occasional reset
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0: v = 16'hFFFF;
                1: v = 16'h0000;
                default: v = 16'($urandom);
            endcase
            step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, v,
                 $urandom_range(0, 39) == 0);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
